mem_access_master: RTL and testbench
====================================

# mem_access_master

Initiator-side memory access engine between the execute stage / matrix unit and `data_memory`. It accepts single or burst load/store requests and drives the `data_memory` request ports (address, write data, read/write enables, `byte_sel`, `mst_or_mvtr`). For loads it returns sign- or zero-extended results on a registered response stream with backpressure. It checks alignment and range before any access is issued.

## Interface

Parameters:
- `DROM_SPACE`, 1024, data memory size in bytes; used for range checks.
- `MAX_BEATS`, 16, maximum burst length in beats.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  engine idle and able to accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  zero-extend loads.
- `req_addr`  in  32  start byte address.
- `req_len`  in  5  beat count, valid range 1..MAX_BEATS.
- `wr_valid`  in  1  store data beat present.
- `wr_ready`  out  1  store beat accepted.
- `wr_data`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  load result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  32  extended load result.
- `rsp_last`  out  1  final beat of the burst.
- `done`  out  1  one-cycle pulse when a request completes or is rejected.
- `err`  out  1  one-cycle pulse together with `done` when a request is rejected.
- `mem_addr`  out  32  to `data_addr`.
- `mem_wdata`  out  32  to `w_data_mem`.
- `mem_ren`  out  1  to `r_en_mem`.
- `mem_wen`  out  1  to `w_en_mem`.
- `mem_byte_sel`  out  2  to `byte_sel`; equals the latched size.
- `mem_mst_or_mvtr`  out  1  to `mst_or_mvtr`; held at 1 so `byte_sel` is always honoured.
- `mem_rdata`  in  32  from `r_data_mem`; combinational, valid in the same cycle as `mem_ren`.

## Operation

- The FSM has three states: IDLE, RD and WR.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, the request is validated. It is rejected if any of the following holds:
    - size is 11;
    - half with `addr[0]`=1;
    - word with `addr[1:0]`≠0;
    - `req_len`=0 or `req_len`>MAX_BEATS;
    - `addr` + len·bytes > DROM_SPACE, where bytes is 1, 2 or 4.
  - Rejected: `err` and `done` pulse in the next cycle, and the FSM stays in IDLE.
  - Accepted: addr, size, unsigned and remaining-beat count are latched, and the FSM moves to RD or WR.
- **RD**
  - A beat issues when `!rsp_valid || rsp_ready`. Only then is `mem_ren`=1, with `mem_addr` = current address.
  - At that clock edge:
    - `rsp_data` is loaded with the extracted value;
    - `rsp_valid` is set to 1;
    - `rsp_last` is set to (remaining==1);
    - the address advances by the beat size;
    - remaining is decremented.
  - When a beat does not issue, `mem_ren`=0.
  - After the last beat issues, the FSM returns to IDLE.
- **WR**
  - `wr_ready`=1.
  - `mem_wen` = `wr_valid`, and `mem_wdata` = `wr_data` (combinational pass-through).
  - Each accepted beat advances the address and decrements remaining. After the last beat, the FSM returns to IDLE.
- **Load extraction** takes byte `mem_rdata[7:0]`, half `[15:0]` or the full word. The value is sign-extended from bit 7 or bit 15 unless `req_unsigned` is set.
- **Response hold:** `rsp_valid` clears on `rsp_ready` when no new beat issues in the same cycle.
- `mem_ren` and `mem_wen` are never both 1.
- `mem_addr` is 0 whenever no access is active.

## Timing

- **Reset values:**
  - `req_ready`=1 after release;
  - `rsp_valid`, `rsp_last`, `done`, `err`, `mem_ren` and `mem_wen` = 0;
  - `rsp_data` and `mem_addr` = 0;
  - state = IDLE.
- **Load latency:** request accepted at edge N → first `mem_ren` in cycle N+1 → `rsp_valid` from N+2. With `rsp_ready` held at 1, a burst sustains one beat per cycle.
- **Completion:** the last beat issues in cycle M → `done`=1 and `req_ready`=1 in cycle M+1. `rsp_valid` for that final beat may still be held by backpressure.
- **Store writes** take effect at the edge that ends the `mem_wen` cycle.
- **Backpressure:** while `rsp_valid`=1 and `rsp_ready`=0, `rsp_data` and `rsp_last` stay stable and `mem_ren`=0.
- **Reset mid-burst:** the burst is abandoned immediately and all outputs take their reset values. Memory bytes already written stay written.

## Test plan

- Word load at 0x08, memory bytes 78 56 34 12 → `rsp_data`=0x12345678, `rsp_last`=1, `done` one cycle after the `mem_ren` cycle.
- Byte 0x80 at 0x04 → signed result 0xFFFFFF80, unsigned result 0x00000080. Half 0x8001 at 0x06 → signed result 0xFFFF8001.
- Burst store of 4 words at 0x20 with one idle `wr_valid` cycle → `mem_wen` pulses at 0x20, 0x24, 0x28, 0x2C with `byte_sel`=10. A following burst load returns the same data with `rsp_last` on beat 4. Dropping `rsp_ready` for 2 cycles mid-burst holds `rsp_data` and keeps `mem_ren`=0.
- Half load at 0x03 → `err`=`done`=1 in the next cycle, no `mem_ren`/`mem_wen`, `req_ready` stays 1.
- Word burst with len 2 at DROM_SPACE−4, and any request with len 0 or 17 → `err`.
- Reset asserted after 2 of 4 store beats → all outputs 0 asynchronously. After release, `req_ready`=1, bytes 0x20–0x27 are updated and 0x28–0x2F are unchanged.

Source files
------------

// File: rtl/mem_access_master.sv
// Initiator-side load/store engine driving data_memory: validates a request,
// then issues single or burst beats with sign/zero-extended load responses.
module mem_access_master #(
    parameter int DROM_SPACE = 1024,
    parameter int MAX_BEATS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [4:0]  req_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [1:0]  mem_byte_sel,
    output logic        mem_mst_or_mvtr,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic [5:0]  MAXB = 6'(MAX_BEATS);
    localparam logic [33:0] SPACE = 34'(DROM_SPACE);

    state_t      state, state_nxt;
    logic [31:0] cur_addr;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [4:0]  rem;

    logic [2:0]  req_bytes;
    logic [33:0] req_end;
    logic        req_bad, accept, reject, issue, wr_beat, last_beat;
    logic [31:0] ext_data;

    always_comb begin
        case (req_size)
            2'b00:   req_bytes = 3'd1;
            2'b01:   req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
    end

    // End address computed wide enough that no legal-looking request can wrap.
    assign req_end = {2'b00, req_addr} + ({29'd0, req_len} * {31'd0, req_bytes});

    assign req_bad = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || (req_len == 5'd0)
                   || ({1'b0, req_len} > MAXB)
                   || (req_end > SPACE);

    assign accept    = (state == IDLE) && req_valid && !req_bad;
    assign reject    = (state == IDLE) && req_valid && req_bad;
    assign issue     = (state == RD) && (!rsp_valid || rsp_ready);
    assign wr_beat   = (state == WR) && wr_valid;
    assign last_beat = (rem == 5'd1);

    always_comb begin
        case (size_q)
            2'b00:   ext_data = uns_q ? {24'd0, mem_rdata[7:0]}
                                      : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            2'b01:   ext_data = uns_q ? {16'd0, mem_rdata[15:0]}
                                      : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        req_ready       = 1'b0;
        wr_ready        = 1'b0;
        mem_ren         = 1'b0;
        mem_wen         = 1'b0;
        mem_addr        = 32'd0;
        mem_wdata       = 32'd0;
        mem_byte_sel    = size_q;
        mem_mst_or_mvtr = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_nxt = req_we ? WR : RD;
            end
            RD: begin
                mem_ren = issue;
                if (issue) begin
                    mem_addr = cur_addr;
                    if (last_beat) state_nxt = IDLE;
                end
            end
            WR: begin
                wr_ready  = 1'b1;
                mem_wen   = wr_valid;
                mem_wdata = wr_data;
                if (wr_valid) begin
                    mem_addr = cur_addr;
                    if (last_beat) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr  <= 32'd0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            rem       <= 5'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_last  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= reject || ((issue || wr_beat) && last_beat);
            err  <= reject;
            if (accept) begin
                cur_addr <= req_addr;
                size_q   <= req_size;
                uns_q    <= req_unsigned;
                rem      <= req_len;
            end else if (issue || wr_beat) begin
                cur_addr <= cur_addr + (32'd1 << size_q);
                rem      <= rem - 5'd1;
            end
            // A fresh beat overwrites the held response; otherwise the consumer drains it.
            if (issue) begin
                rsp_valid <= 1'b1;
                rsp_data  <= ext_data;
                rsp_last  <= last_beat;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: byte-array memory model plus a response scoreboard.
module tb_mem_access_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'd0;
    logic [4:0]  req_len = 5'd0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, wr_ready, rsp_valid, rsp_last, done, err;
    logic [31:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen, mem_mst_or_mvtr;
    logic [1:0]  mem_byte_sel;

    logic [7:0]  mem [1024];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [7:0]  pl_data = 8'd0;

    typedef struct packed { logic [31:0] d; logic l; } rsp_t;
    rsp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    logic [31:0] W [4];
    logic [31:0] V [4];

    mem_access_master #(.DROM_SPACE(1024), .MAX_BEATS(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_len(req_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .done(done), .err(err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_byte_sel(mem_byte_sel), .mem_mst_or_mvtr(mem_mst_or_mvtr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Little-endian combinational read port
    always_comb begin
        mem_rdata = {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
                     mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]};
    end

    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr[9:0]] <= mem_wdata[7:0];
            if (mem_byte_sel != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
            if (mem_byte_sel == 2'b10) begin
                mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
                mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
            end
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
    end

    // Scoreboard: every response handshake pops one expected beat
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got=%h last=%b expected none", rsp_data, rsp_last);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                if (rsp_data !== e.d || rsp_last !== e.l) begin
                    errors++;
                    $display("FAIL rsp_beat got=%h/%b expected=%h/%b", rsp_data, rsp_last, e.d, e.l);
                end
            end
        end
    end

    function automatic logic [31:0] word_at(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pl(input int a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = 10'(a); pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic send_req(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [4:0] len);
        int n = 0;
        while (!req_ready && n < 100) begin tick(); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout got=0 expected=1");
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_len = len;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 40) begin tick(); n++; end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s done_timeout got=0 expected=1", name);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin tick(); n++; end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain got=%0d pending expected=0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({rsp_valid, rsp_last, done, err, mem_ren, mem_wen, wr_ready} !== 7'd0
            || mem_addr !== 32'd0 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b addr=%h data=%h expected=0",
                     {rsp_valid, rsp_last, done, err, mem_ren, mem_wen, wr_ready}, mem_addr, rsp_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release req_ready=%b done=%b expected 1/0", req_ready, done);
        end
    endtask

    task automatic test_word_load();
        pl(8, 8'h78); pl(9, 8'h56); pl(10, 8'h34); pl(11, 8'h12);
        sb_q.push_back({32'h12345678, 1'b1});
        send_req(1'b0, 2'b10, 1'b0, 32'h8, 5'd1);
        checks++;
        if (mem_ren !== 1'b1 || mem_addr !== 32'h8 || mem_byte_sel !== 2'b10 || done !== 1'b0) begin
            errors++;
            $display("FAIL word_issue ren=%b addr=%h bsel=%b done=%b expected 1/8/10/0",
                     mem_ren, mem_addr, mem_byte_sel, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b1 || mem_ren !== 1'b0) begin
            errors++;
            $display("FAIL word_done done=%b err=%b rdy=%b rv=%b ren=%b expected 1/0/1/1/0",
                     done, err, req_ready, rsp_valid, mem_ren);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL word_done_pulse got=%b expected=0", done);
        end
        drain("word_load");
    endtask

    task automatic load1(input string name, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp);
        sb_q.push_back({exp, 1'b1});
        send_req(1'b0, sz, uns, a, 5'd1);
        wait_done(name);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL %s err got=%b expected=0", name, err);
        end
        drain(name);
    endtask

    task automatic test_byte_half();
        pl(4, 8'h80); pl(6, 8'h01); pl(7, 8'h80);
        load1("byte_signed",   2'b00, 1'b0, 32'h4, 32'hFFFFFF80);
        load1("byte_unsigned", 2'b00, 1'b1, 32'h4, 32'h00000080);
        load1("half_signed",   2'b01, 1'b0, 32'h6, 32'hFFFF8001);
        load1("half_unsigned", 2'b01, 1'b1, 32'h6, 32'h00008001);
    endtask

    task automatic test_store_burst();
        int k;
        send_req(1'b1, 2'b10, 1'b0, 32'h20, 5'd4);
        for (int i = 0; i < 5; i++) begin
            k = (i < 2) ? i : i - 1;
            if (i == 2) wr_valid = 1'b0;
            else begin wr_valid = 1'b1; wr_data = W[k]; end
            #1;
            checks++;
            if (mem_wen !== (i != 2) || wr_ready !== 1'b1 || mem_ren !== 1'b0
                || mem_addr !== ((i == 2) ? 32'd0 : 32'h20 + 32'(4 * k))
                || mem_byte_sel !== 2'b10) begin
                errors++;
                $display("FAIL store_beat%0d wen=%b rdy=%b addr=%h bsel=%b expected wen=%b addr=%h",
                         i, mem_wen, wr_ready, mem_addr, mem_byte_sel, (i != 2),
                         (i == 2) ? 32'd0 : 32'h20 + 32'(4 * k));
            end
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || req_ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL store_done done=%b rdy=%b err=%b expected 1/1/0", done, req_ready, err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (word_at(32 + 4 * i) !== W[i]) begin
                errors++;
                $display("FAIL store_mem%0d got=%h expected=%h", i, word_at(32 + 4 * i), W[i]);
            end
        end
    endtask

    task automatic test_load_backpressure();
        for (int i = 0; i < 4; i++) sb_q.push_back({W[i], i == 3});
        send_req(1'b0, 2'b10, 1'b0, 32'h20, 5'd4);
        tick();
        tick();
        rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== W[1] || rsp_last !== 1'b0 || mem_ren !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d rv=%b data=%h last=%b ren=%b expected 1/%h/0/0",
                         i, rsp_valid, rsp_data, rsp_last, mem_ren, W[1]);
            end
            if (i < 2) tick();
        end
        rsp_ready = 1'b1;
        wait_done("burst_load");
        drain("burst_load");
    endtask

    task automatic rej(input string name, input logic [1:0] sz, input logic [31:0] a,
                       input logic [4:0] len);
        send_req(1'b0, sz, 1'b0, a, len);
        checks++;
        if (err !== 1'b1 || done !== 1'b1 || req_ready !== 1'b1 || mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL %s err=%b done=%b rdy=%b ren=%b wen=%b expected 1/1/1/0/0",
                     name, err, done, req_ready, mem_ren, mem_wen);
        end
        tick();
        checks++;
        if (err !== 1'b0 || mem_ren !== 1'b0) begin
            errors++;
            $display("FAIL %s err_pulse err=%b ren=%b expected 0/0", name, err, mem_ren);
        end
    endtask

    task automatic test_reject();
        rej("half_misaligned", 2'b01, 32'h3, 5'd1);
        rej("word_misaligned", 2'b10, 32'h2, 5'd1);
        rej("range_over",      2'b10, 32'd1020, 5'd2);
        rej("len_zero",        2'b10, 32'h0, 5'd0);
        rej("len_17",          2'b10, 32'h0, 5'd17);
        rej("size_illegal",    2'b11, 32'h0, 5'd1);
        pl(1020, 8'hEF); pl(1021, 8'hBE); pl(1022, 8'hAD); pl(1023, 8'hDE);
        load1("range_edge", 2'b10, 1'b0, 32'd1020, 32'hDEADBEEF);
    endtask

    task automatic test_reset_mid();
        send_req(1'b1, 2'b10, 1'b0, 32'h20, 5'd4);
        wr_valid = 1'b1; wr_data = V[0];
        tick();
        wr_data = V[1];
        tick();
        wr_data = V[2];
        rst = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_last, done, err, mem_ren, mem_wen, wr_ready} !== 7'd0
            || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs got=%b addr=%h wdata=%h expected=0",
                     {rsp_valid, rsp_last, done, err, mem_ren, mem_wen, wr_ready}, mem_addr, mem_wdata);
        end
        wr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release rdy=%b done=%b expected 1/0", req_ready, done);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (word_at(32 + 4 * i) !== ((i < 2) ? V[i] : W[i])) begin
                errors++;
                $display("FAIL midreset_mem%0d got=%h expected=%h", i, word_at(32 + 4 * i),
                         (i < 2) ? V[i] : W[i]);
            end
        end
    endtask

    initial begin
        W[0] = 32'hA1B2C3D4; W[1] = 32'h11223344; W[2] = 32'h55667788; W[3] = 32'h99AABBCC;
        V[0] = 32'hCAFEF00D; V[1] = 32'h0BADBEEF; V[2] = 32'h13572468; V[3] = 32'h24681357;
        test_reset();
        test_word_load();
        test_byte_half();
        test_store_burst();
        test_load_backpressure();
        test_reject();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
